rv_output_buffer: RTL and testbench

- Elastic output stage placed directly downstream of a latency-insensitive compute module's ready-valid controller.
- Captures each result when the producer's valid is high and this block's ready is high, then holds it until the consumer accepts it.
- Decouples the producer's VALID->IDLE transition from consumer stalls, so the producer can return to IDLE and accept new work while earlier results drain.
- In-order circular FIFO with a registered-only upstream ready.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/rv_buffer_mem.sv | 38 +++
 rtl/rv_output_buffer.sv | 119 +++++++++++
 tb/tb_rv_output_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the ready-valid compute slice.
//   rv_state_t  : state encoding of the upstream ready-valid controller
//   ptr_width() : pointer width for a circular buffer of a given depth,
//                 $clog2(depth) but never narrower than one bit
// -----------------------------------------------------------------------------
package rv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        VALID   = 2'b10
    } rv_state_t;

    // A depth of 1 would give a zero-width pointer; keep one bit so the
    // pointer registers and compares stay well formed.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rv_buffer_mem.sv
// -----------------------------------------------------------------------------
// rv_buffer_mem
// DEPTH x WIDTH storage for the output buffer: one write port with write
// enable, asynchronous read by index. The contents are not reset.
// Ports:
//   clk    : clock, write on rising edge
//   we     : write enable
//   waddr  : write index
//   wdata  : write payload
//   raddr  : read index
//   rdata  : payload at raddr (combinational)
// -----------------------------------------------------------------------------
module rv_buffer_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The head entry must be visible in the same cycle the read pointer
    // moves, so the read is combinational.
    assign rdata = mem[raddr];

endmodule

// File: rtl/rv_output_buffer.sv
// -----------------------------------------------------------------------------
// rv_output_buffer
// Elastic in-order output stage behind a ready-valid producer. Results are
// captured on push (in_valid && in_ready) and held in a circular FIFO until
// the consumer pops them (out_valid && out_ready). in_ready depends only on
// registered occupancy, so there is no out_ready -> in_ready path; when the
// buffer is full a pop in the same cycle does not open the input.
//
// Optional build macro RV_OUTPUT_BUFFER_BYPASS_EN: when empty and both
// in_valid and out_ready are high, the input passes straight to the output
// in that cycle without touching storage, pointers or count.
//
// Ports:
//   clk       : clock
//   reset     : synchronous active-high reset, discards all entries
//   in_valid  : producer result valid
//   in_ready  : buffer can accept a result (registered state only)
//   in_data   : producer result
//   out_valid : head entry valid
//   out_ready : consumer accepts head entry
//   out_data  : head entry payload
//   count     : current occupancy
// -----------------------------------------------------------------------------
module rv_output_buffer
    import rv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic [WIDTH-1:0] rd_data;
    logic             not_empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg < CW'(DEPTH));

`ifdef RV_OUTPUT_BUFFER_BYPASS_EN
    assign bypass = !not_empty && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat is neither stored nor popped from storage.
    assign push = in_valid && in_ready && !bypass;
    assign pop  = not_empty && out_ready;

    assign out_valid = not_empty || bypass;
    assign out_data  = bypass ? in_data : rd_data;
    assign count     = count_reg;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage writes are gated by reset so a handshake in the reset cycle
    // leaves no trace (contents are don't-care anyway once count is zero).
    rv_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !reset),
        .waddr (wr_ptr_reg),
        .wdata (in_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_rv_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_rv_output_buffer
// Drives a DEPTH=2 and a DEPTH=3 instance of rv_output_buffer. Each cycle the
// bench model (one queue per instance) predicts in_ready, out_valid, count
// and out_data; accepted inputs are pushed to the queue and consumed outputs
// are popped from it and compared.
// -----------------------------------------------------------------------------
module tb_rv_output_buffer;

    localparam int W = 8;
    localparam int DEP [2] = '{2, 3};

`ifdef RV_OUTPUT_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         iv   [2];
    logic         ir   [2];
    logic [W-1:0] idat [2];
    logic         ov   [2];
    logic         ordy [2];
    logic [W-1:0] odat [2];
    logic [1:0]   cnt  [2];

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    int tests  = 0;
    int fails  = 0;
    int npop   [2] = '{0, 0};

    always #5 clk = ~clk;

    rv_output_buffer #(.WIDTH(W), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]),
        .count(cnt[0])
    );

    rv_output_buffer #(.WIDTH(W), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]),
        .count(cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    // One clock cycle: drive instance sel, idle the other, check both against
    // the model, update the model with the handshakes, then advance the clock.
    task automatic cycle(input int sel, input bit v, input logic [W-1:0] d, input bit r);
        for (int s = 0; s < 2; s++) begin
            iv[s]   = (s == sel) ? v : 1'b0;
            idat[s] = (s == sel) ? d : '0;
            ordy[s] = (s == sel) ? r : 1'b0;
        end
        #4;
        for (int s = 0; s < 2; s++) begin
            int           sz;
            bit           byp;
            bit           exp_v;
            logic [W-1:0] exp_d;
            sz    = qsize(s);
            byp   = BYP && (sz == 0) && iv[s] && ordy[s];
            exp_v = (sz != 0) || byp;
            check($sformatf("d%0d_in_ready", DEP[s]), 32'(ir[s]), 32'(sz < DEP[s]));
            check($sformatf("d%0d_out_valid", DEP[s]), 32'(ov[s]), 32'(exp_v));
            check($sformatf("d%0d_count", DEP[s]), 32'(cnt[s]), 32'(sz));
            if (iv[s] && (sz < DEP[s])) begin
                if (s == 0) q0.push_back(idat[s]); else q1.push_back(idat[s]);
                $display("[TB] d%0d push 0x%02h", DEP[s], idat[s]);
            end
            if (exp_v) begin
                exp_d = (s == 0) ? q0[0] : q1[0];
                check($sformatf("d%0d_out_data", DEP[s]), 32'(odat[s]), 32'(exp_d));
                if (ordy[s]) begin
                    if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    npop[s]++;
                    $display("[TB] d%0d pop  0x%02h", DEP[s], exp_d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit v, input bit r);
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            iv[s] = v; idat[s] = 8'hEE; ordy[s] = r;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        $display("[TB] reset");
    endtask

    initial begin
        int          val;
        int          budget;
        logic [W-1:0] bv;
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; idat[s] = '0; ordy[s] = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // idle after reset
        for (int i = 0; i < 3; i++) cycle(0, 1'b0, '0, 1'b0);

        // DEPTH=2 fill, hold-off, drain
        cycle(0, 1'b1, 8'hA1, 1'b0);
        cycle(0, 1'b1, 8'hA2, 1'b0);
        cycle(0, 1'b1, 8'hA3, 1'b0);   // full, A3 held off
        cycle(0, 1'b1, 8'hA3, 1'b0);
        cycle(0, 1'b1, 8'hA3, 1'b1);   // full: pop only
        cycle(0, 1'b1, 8'hA3, 1'b1);   // A3 accepted, A2 popped
        cycle(0, 1'b0, '0, 1'b1);
        cycle(0, 1'b0, '0, 1'b0);
        check("d2_a_popped", 32'(npop[0]), 32'd3);

        // count=1 simultaneous push and pop
        cycle(0, 1'b1, 8'hB1, 1'b0);
        cycle(0, 1'b1, 8'hB2, 1'b1);
        cycle(0, 1'b0, '0, 1'b0);
        cycle(0, 1'b0, '0, 1'b1);
        cycle(0, 1'b0, '0, 1'b0);

        // DEPTH=3 random stalls with wrap-around
        val    = 0;
        budget = 0;
        while ((val < 10) && (budget < 200)) begin
            bit stall_in;
            bit acc;
            stall_in = ($urandom_range(0, 3) == 0);
            acc      = !stall_in && (q1.size() < 3);
            cycle(1, !stall_in, 8'(val), 1'($urandom_range(0, 1)));
            if (acc) val++;
            budget++;
        end
        check("d3_all_pushed", 32'(val), 32'd10);
        budget = 0;
        while ((q1.size() != 0) && (budget < 20)) begin
            cycle(1, 1'b0, '0, 1'b1);
            budget++;
        end
        cycle(1, 1'b0, '0, 1'b0);
        check("d3_drained", 32'(q1.size()), 32'd0);
        check("d3_pop_total", 32'(npop[1]), 32'd10);

        // reset while full, with a handshake offered in the reset cycle
        cycle(0, 1'b1, 8'hD1, 1'b0);
        cycle(0, 1'b1, 8'hD2, 1'b0);
        do_reset(1'b1, 1'b1);
        cycle(0, 1'b0, '0, 1'b0);
        cycle(0, 1'b0, '0, 1'b0);

        // empty push with consumer ready (bypass when enabled)
        bv = 8'hC5;
        cycle(0, 1'b1, bv, 1'b1);
        cycle(0, 1'b0, '0, 1'b1);
        cycle(0, 1'b0, '0, 1'b0);
        check("d2_c5_seen", 32'(npop[0]), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
